// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read-port CPU register file with an optional hardwired
//            zero entry, optional write-to-read bypass, optional registered
//            read data, and a built-in sequencer that clears every entry after
//            reset.
// Ports    : clk_i     - clock, all state changes on the rising edge
//            rst_i     - synchronous active-high reset, starts the clear sweep
//            we_i      - write enable
//            waddr_i   - write address
//            wdata_i   - write data
//            raddr_i   - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//            rdata_o   - packed read data, port k at [k*DATA_W +: DATA_W]
//            busy_o    - high while the clear sweep runs
//            wr_drop_o - one-cycle pulse for each write dropped during clear
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic                     busy_o,
  output logic                     wr_drop_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              busy;
  logic              wr_en;
  logic              drop_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: leave CLEAR on the edge that writes the last entry
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (cnt == CNT_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == ST_CLEAR);
  end

  assign busy_o    = busy;
  assign wr_drop_o = drop_q;

  // Clear sweep pointer; wraps back to 0 on the final clear edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // A write arriving while the sweep runs is reported one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= busy & we_i;
    end
  end

  // Writes to entry 0 are discarded silently when it is hardwired to zero.
  assign wr_en = we_i && !((ZERO_REG != 0) && (waddr_i == '0));

  // Storage array. Reset does not touch it directly: the sweep clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        mem[waddr_i] <= wdata_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] eff;

    assign ra = raddr_i[k*ADDR_W +: ADDR_W];

    // The busy check also guarantees bypass only applies in RUN.
    always_comb begin
      eff = mem[ra];
      if (busy) begin
        eff = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        eff = '0;
      end else if ((BYPASS != 0) && we_i && (waddr_i == ra)) begin
        eff = wdata_i;
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_q <= '0;
        end else begin
          rd_q <= eff;
        end
      end
      assign rdata_o[k*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign rdata_o[k*DATA_W +: DATA_W] = eff;
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write/single-read CPU register file.
- Provides NUM_RD independent read ports, configurable width and depth, an optional hardwired-zero entry 0, optional write-to-read bypass, and an optional registered-read mode.
- After reset, a built-in sequencer clears every entry to zero, so simulation and FPGA builds start from a known register state.
- Sits between the urv_cpu decode stage (read addresses) and the writeback stage (write port).

Parameters:
- DATA_W, 32: width of each register in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a same-cycle write to an address being read is forwarded to that read port.
- READ_REG, 0: 0 gives combinational read (latency 0); 1 gives read data registered on clk_i (latency 1).

Ports:
- clk_i, input, 1: clock; all state changes on its rising edge.
- rst_i, input, 1: synchronous reset, active-high; starts the clear sequence.
- we_i, input, 1: write enable.
- waddr_i, input, ADDR_W: write address.
- wdata_i, input, DATA_W: write data.
- raddr_i, input, NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata_o, output, NUM_RD*DATA_W: read data; port k drives bits [k*DATA_W +: DATA_W].
- busy_o, output, 1: high while the clear sequence runs.
- wr_drop_o, output, 1: one-cycle pulse when a write was discarded because the clear was running.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- States: CLEAR and RUN.
- On any edge with rst_i=1:
  - state becomes CLEAR and the clear counter becomes 0;
  - busy_o becomes 1 and wr_drop_o becomes 0;
  - the registered rdata_o (READ_REG=1) becomes 0;
  - no array write occurs on that edge.
- CLEAR, each edge with rst_i=0:
  - writes 0 to entry[cnt], then cnt increments;
  - when cnt = DEPTH-1 is written, go to RUN; busy_o falls on that same edge;
  - CLEAR lasts exactly DEPTH cycles after rst_i deasserts.
- Reset asserted during CLEAR restarts the sweep at entry 0.
- While busy_o=1:
  - rdata_o reads 0 on all ports;
  - an external write is ignored (we_i=1 → wr_drop_o=1 on the next cycle, for one cycle per dropped write).
- RUN, write: if we_i=1, entry[waddr_i] <= wdata_i on the edge. If ZERO_REG=1 and waddr_i=0, the write is silently discarded (no wr_drop_o).
- Read value for port k ("eff" value):
  - 0 if ZERO_REG=1 and raddr_k=0;
  - otherwise, if BYPASS=1, we_i=1, waddr_i=raddr_k and state=RUN: wdata_i;
  - otherwise entry[raddr_k].
- Read timing:
  - READ_REG=0: rdata_o equals the eff value combinationally, in the same cycle.
  - READ_REG=1: rdata_o is registered with the eff value at the edge, so the write is visible with latency 1 (write-first).
- BYPASS=0 and READ_REG=0: a same-cycle read returns the old content; the new value appears the next cycle.
- All read ports are fully independent; the same address on several ports gives identical data.
- No read/write port conflicts exist. The single write port is always accepted in RUN.
- Entry contents are never X after the clear completes.
- Implementation: register array plus counter. No vendor RAM primitives, because NUM_RD>1 needs replicated or flop storage.

Test Plan:
- Reset (defaults DEPTH=32): hold rst_i=1 for 2 cycles, then release → busy_o=1 for exactly 32 cycles. Then read every address on both ports → 0x00000000.
- Write-then-read (READ_REG=0, BYPASS=1):
  - we_i=1, waddr_i=5, wdata_i=0xDEADBEEF, raddr port0=5 in the same cycle → rdata port0=0xDEADBEEF in that cycle.
  - Next cycle with we_i=0 → still 0xDEADBEEF.
- Zero register: write 0x12345678 to addr 0 → both ports reading addr 0 return 0; wr_drop_o stays 0.
- Write during clear: pulse we_i=1 with waddr_i=3, wdata_i=0xAAAA5555 at clear cycle 10 → wr_drop_o=1 on the next cycle only. After busy_o falls, addr 3 reads 0.
- Registered mode (READ_REG=1, BYPASS=0, NUM_RD=4):
  - write 0x1 to addr 7 while all four ports read 7 → rdata shows the old value 0 one cycle later, then 0x1 the following cycle.
  - Repeat with BYPASS=1 → 0x1 one cycle later.
- Reset mid-clear: assert rst_i at clear cycle 20 → busy_o stays 1 and stays high for a full 32 cycles after release. A random-write scoreboard over 10k cycles then shows no mismatches.
